// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, feeds IF/ID (NOP bubble when empty) and drops stale responses.
module fetch_unit #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h00000013)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  StallF,
   input  logic                  PCSrcE,
   input  logic [DATA_WIDTH-1:0] PCTargetE,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] InstrF,
   output logic [DATA_WIDTH-1:0] PCF,
   output logic [DATA_WIDTH-1:0] PC_plus_4F,
   output logic                  FetchValidF
);

   localparam logic [1:0] ST_ISSUE   = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [1:0] ST_DISCARD = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] buf_q;
   logic                  buf_valid_q, buf_valid_d;
   logic                  buf_load;

   logic [DATA_WIDTH-1:0] pc_inc;
   logic [DATA_WIDTH-1:0] target_aligned;
   logic                  rsp_bypass;
   logic                  hold_valid;

   assign pc_inc         = pc_q + DATA_WIDTH'(4);
   // Low target bits are cleared rather than sliced off so every input bit is consumed.
   assign target_aligned = PCTargetE & ~DATA_WIDTH'(3);

   assign rsp_bypass = (state_q == ST_WAIT) && imem_rvalid;
   assign hold_valid = (state_q == ST_HOLD) && buf_valid_q;

   assign imem_req    = !rst && (state_q == ST_ISSUE);
   assign imem_addr   = pc_q;
   assign PCF         = pc_q;
   assign PC_plus_4F  = pc_inc;
   assign FetchValidF = !rst && (rsp_bypass || hold_valid);

   always_comb begin
      InstrF = NOP_INSTR;
      if (FetchValidF) begin
         InstrF = hold_valid ? buf_q : imem_rdata;
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; a missing default would infer a latch.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      buf_valid_d = buf_valid_q;
      buf_load    = 1'b0;

      case (state_q)
         ST_ISSUE: begin
            // The request still goes out on a redirect; its response becomes stale.
            state_d = PCSrcE ? ST_DISCARD : ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               if (PCSrcE || !StallF) begin
                  state_d = ST_ISSUE;
               end else begin
                  state_d     = ST_HOLD;
                  buf_load    = 1'b1;
                  buf_valid_d = 1'b1;
               end
               if (!PCSrcE && !StallF) begin
                  pc_d = pc_inc;
               end
            end else if (PCSrcE) begin
               state_d = ST_DISCARD;
            end
         end
         ST_HOLD: begin
            if (PCSrcE || !StallF) begin
               state_d     = ST_ISSUE;
               buf_valid_d = 1'b0;
               if (!PCSrcE) begin
                  pc_d = pc_inc;
               end
            end
         end
         ST_DISCARD: begin
            if (imem_rvalid) begin
               state_d = ST_ISSUE;
            end
         end
         default: state_d = ST_ISSUE;
      endcase

      if (PCSrcE) begin
         pc_d        = target_aligned;
         buf_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its inputs regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ISSUE;
         pc_q        <= RESET_PC;
         buf_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_valid_q <= buf_valid_d;
      end
   end

   // NOTE: the instruction buffer is data storage qualified by buf_valid_q, so it
   // carries no reset and stays a plain enable flop.
   always_ff @(posedge clk) begin
      if (buf_load) begin
         buf_q <= imem_rdata;
      end
   end

endmodule
